// File: rtl/eth_tx_gen.sv
// Ethernet test-frame generator: header, counting payload, zero pad,
// streamed byte-wide over AXI-Stream to a MAC.
module eth_tx_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0A00_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] payload_len,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  output logic        tx_axis_tuser,
  input  logic        tx_axis_tready
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PAD
  } state_t;

  localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [10:0]  MAX_LEN   = 11'd1500;

  state_t      state;
  state_t      nxt_state;
  logic [10:0] len_q;
  logic [7:0]  seed_q;
  logic [10:0] idx;
  logic [10:0] nxt;
  logic [10:0] last_idx;
  logic [10:0] pay_end;
  logic [7:0]  nxt_byte;
  logic [111:0] hdr_sh;
  logic [10:0] pay_off;

  // idx is the frame offset of the byte currently on tdata
  assign nxt      = idx + 11'd1;
  assign pay_end  = len_q + 11'd14;
  assign last_idx = (len_q < 11'd46) ? 11'd59 : len_q + 11'd13;
  assign hdr_sh   = HDR_BYTES << {nxt[3:0], 3'b000};
  assign pay_off  = nxt - 11'd14;

  assign tx_axis_tuser = 1'b0;

  always_comb begin
    nxt_state = PAD;
    nxt_byte  = 8'h00;
    unique case (1'b1)
      (nxt < 11'd14): begin
        nxt_state = HDR;
        nxt_byte  = hdr_sh[111:104];
      end
      (nxt >= 11'd14 && nxt < pay_end): begin
        nxt_state = PAYLOAD;
        nxt_byte  = seed_q + pay_off[7:0];
      end
      default: begin
        nxt_state = PAD;
        nxt_byte  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      len_q          <= '0;
      seed_q         <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      frame_cnt      <= '0;
      tx_axis_tdata  <= '0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q          <= (payload_len > MAX_LEN) ? MAX_LEN
                                                      : payload_len;
            seed_q         <= frame_cnt[7:0];
            idx            <= '0;
            busy           <= 1'b1;
            state          <= HDR;
            tx_axis_tdata  <= DST_MAC[47:40];
            tx_axis_tvalid <= 1'b1;
            tx_axis_tlast  <= 1'b0;
          end
        end
        default: begin
          if (tx_axis_tvalid && tx_axis_tready) begin
            if (tx_axis_tlast) begin
              state          <= IDLE;
              busy           <= 1'b0;
              frame_cnt      <= frame_cnt + 16'd1;
              tx_axis_tdata  <= '0;
              tx_axis_tvalid <= 1'b0;
              tx_axis_tlast  <= 1'b0;
            end else begin
              idx           <= nxt;
              state         <= nxt_state;
              tx_axis_tdata <= nxt_byte;
              tx_axis_tlast <= (nxt == last_idx);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_gen.sv
// Directed bench for eth_tx_gen: frame contents, stalls, start
// filtering, mid-frame reset and frame counter wrap.
module tb_eth_tx_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] payload_len;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic        tready;

  always #5 clk = ~clk;

  eth_tx_gen dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .payload_len    (payload_len),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .tx_axis_tdata  (tdata),
    .tx_axis_tvalid (tvalid),
    .tx_axis_tlast  (tlast),
    .tx_axis_tuser  (tuser),
    .tx_axis_tready (tready)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] got [0:1599];
  logic       gotlast [0:1599];
  int n;
  int cyc;
  int stall_bad;
  int tuser_bad;
  int busy_bad;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int l,
                                          input logic [7:0] seed);
    logic [7:0] hdr [0:13];
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h88, 8'hB5};
    if (i < 14) return hdr[i];
    if (i < 14 + l) return seed + 8'(i - 14);
    return 8'h00;
  endfunction

  task automatic run_frame(input int len, input bit rnd, input bit spam);
    bit done;
    bit pv;
    logic [7:0] pd;
    logic pl;
    @(negedge clk);
    payload_len = 11'(len);
    start = 1'b1;
    tready = 1'b1;
    @(negedge clk);
    start = spam;
    payload_len = 11'(len) ^ 11'h2A5;
    n = 0;
    cyc = 0;
    stall_bad = 0;
    tuser_bad = 0;
    busy_bad = 0;
    done = 1'b0;
    pv = 1'b0;
    while (!done && cyc < 5000) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tuser !== 1'b0) tuser_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (tvalid === 1'b1) begin
        if (pv && (tdata !== pd || tlast !== pl)) stall_bad++;
        if (tready) begin
          if (n < 1600) begin
            got[n] = tdata;
            gotlast[n] = tlast;
          end
          n++;
          done = (tlast === 1'b1);
          pv = 1'b0;
        end else begin
          pv = 1'b1;
          pd = tdata;
          pl = tlast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tready = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int len,
                             input logic [7:0] seed,
                             input logic [15:0] exp_cnt,
                             input bit chk_cyc);
    int l;
    int nexp;
    int bad;
    int lbad;
    l = (len > 1500) ? 1500 : len;
    nexp = 14 + ((l < 46) ? 46 : l);
    chk({tag, " bytes"}, n, nexp);
    bad = 0;
    lbad = 0;
    for (int i = 0; i < n && i < 1600; i++) begin
      if (got[i] !== exp_byte(i, l, seed)) bad++;
      if (gotlast[i] !== (i == nexp - 1)) lbad++;
    end
    chk({tag, " data_bad"}, bad, 0);
    chk({tag, " tlast_bad"}, lbad, 0);
    chk({tag, " stall_bad"}, stall_bad, 0);
    chk({tag, " tuser_bad"}, tuser_bad, 0);
    chk({tag, " busy_in_frame_bad"}, busy_bad, 0);
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " tvalid_after"}, tvalid, 0);
    chk({tag, " frame_cnt"}, frame_cnt, exp_cnt);
    if (chk_cyc) chk({tag, " cycles"}, cyc, nexp);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    start = 1'b0;
    tready = 1'b0;
    payload_len = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst tvalid", tvalid, 0);
    chk("rst tlast", tlast, 0);
    chk("rst tdata", tdata, 0);
    chk("rst tuser", tuser, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // minimum frame, start held high throughout
    run_frame(0, 1'b0, 1'b1);
    check_frame("L0", 0, 8'h00, 16'd1, 1'b1);
    chk("L0 b6", got[6], 8'h0A);
    chk("L0 b12", got[12], 8'h88);
    chk("L0 b59", got[59], 8'h00);
    repeat (3) @(negedge clk);
    chk("L0 no_requeue tvalid", tvalid, 0);
    chk("L0 no_requeue cnt", frame_cnt, 16'd1);

    run_frame(50, 1'b1, 1'b0);
    check_frame("L50rnd", 50, 8'h01, 16'd2, 1'b0);
    chk("L50rnd b63", got[63], 8'h32);

    // mid-frame reset
    @(negedge clk);
    payload_len = 11'd50;
    start = 1'b1;
    tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid tvalid", tvalid, 1);
    rst = 1'b1;
    #1;
    chk("mid rst tvalid", tvalid, 0);
    chk("mid rst tlast", tlast, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(3, 1'b0, 1'b0);
    check_frame("post_rst", 3, 8'h00, 16'd1, 1'b1);

    guard = 0;
    while (frame_cnt !== 16'h00FE && guard < 300) begin
      run_frame(0, 1'b0, 1'b0);
      guard++;
    end
    chk("fill cnt", frame_cnt, 16'h00FE);

    run_frame(100, 1'b0, 1'b0);
    check_frame("L100", 100, 8'hFE, 16'h00FF, 1'b1);
    chk("L100 b14", got[14], 8'hFE);
    chk("L100 b16", got[16], 8'h00);
    chk("L100 b113", got[113], 8'h61);

    run_frame(2000, 1'b0, 1'b0);
    check_frame("L2000", 2000, 8'hFF, 16'h0100, 1'b1);
    chk("L2000 last", got[1513], 8'hDA);
    chk("L2000 lastflag", gotlast[1513], 1);

    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    chk("preset cnt", frame_cnt, 16'hFFFF);
    run_frame(10, 1'b0, 1'b0);
    check_frame("wrap", 10, 8'hFF, 16'h0000, 1'b1);
    chk("wrap b15", got[15], 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_gen.md
ETH_TX_GEN -- requirements
Module: eth_tx_gen

Interface
REQ-001 SHALL have parameter DST_MAC, default 48'hFFFF_FFFF_FFFF, destination MAC, sent first.
REQ-002 SHALL have parameter SRC_MAC, default 48'h0A00_0000_0001, source MAC.
REQ-003 SHALL have parameter ETHERTYPE, default 16'h88B5, type field.
REQ-004 SHALL have port clk  input  1  single clock domain; same domain as MAC tx_mac_aclk.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  frame request; sampled only in IDLE.
REQ-007 SHALL have port payload_len  input  11  requested payload bytes; latched when start is accepted.
REQ-008 SHALL have port busy  output  1  high from start acceptance until the last byte is accepted.
REQ-009 SHALL have port frame_cnt  output  16  count of completed frames.
REQ-010 SHALL have port tx_axis_tdata  output  8  AXI-Stream byte to MAC.
REQ-011 SHALL have port tx_axis_tvalid  output  1  byte valid.
REQ-012 SHALL have port tx_axis_tlast  output  1  final byte of frame.
REQ-013 SHALL have port tx_axis_tuser  output  1  frame error flag to MAC.
REQ-014 SHALL have port tx_axis_tready  input  1  MAC accept.

Function
REQ-015 SHALL implement states IDLE, HDR, PAYLOAD, PAD; transitions only on clk rising edge.
REQ-016 IDLE: start=1 SHALL latch L = min(payload_len,1500), latch seed = frame_cnt[7:0], set busy, go HDR.
REQ-017 tx_axis_tvalid SHALL rise the cycle after start is sampled, with tdata = DST_MAC[47:40].
REQ-018 HDR SHALL emit 14 bytes MSB-first: DST_MAC, SRC_MAC, ETHERTYPE; go PAYLOAD if L>0, else PAD.
REQ-019 PAYLOAD byte i (0..L-1) SHALL equal (seed + i) mod 256, 8-bit wrap.
REQ-020 PAD SHALL emit 8'h00 for 46-L bytes when L<46; L>=46 SHALL skip PAD.
REQ-021 Total frame bytes SHALL be 14 + max(L,46); range 60..1514.
REQ-022 tx_axis_tlast SHALL be high only with the final byte; tx_axis_tuser SHALL be constant 0.
REQ-023 A byte SHALL advance only on tvalid & tready; while tvalid & !tready, tdata/tlast SHALL hold.
REQ-024 tvalid SHALL stay high continuously from first to last byte (no bubbles when tready=1).
REQ-025 On last-byte accept: next state IDLE, tvalid=0, busy=0, frame_cnt+1 (16-bit wrap 16'hFFFF->0), same edge.
REQ-026 start while busy=1 SHALL be ignored, including the last-byte-accept cycle; no queuing.
REQ-027 payload_len changes after acceptance SHALL not affect the frame in flight.
REQ-028 Throughput at tready=1: start in IDLE at cycle 0 -> bytes on cycles 1..N, busy low cycle N+1, next start accepted N+1.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, busy=0, tvalid=0, tlast=0, tdata=0, tuser=0, frame_cnt=0.
REQ-030 rst mid-frame SHALL abort without tlast; frame_cnt not incremented; first start after release begins a fresh frame at DST_MAC[47:40].

Verification
REQ-031 L=0, tready=1: start -> 60 bytes: FF x6, 0A 00 00 00 00 01, 88 B5, 46x 00; tlast on byte 60; frame_cnt=1.
REQ-032 L=100, frame_cnt=16'h00FE: payload bytes FE,FF,00,01..61; no pad; 114 bytes; frame_cnt=16'h00FF.
REQ-033 L=2000: clamped; 1514 bytes; last payload byte = (seed+1499) mod 256 with tlast.
REQ-034 L=50, random tready (~50%) -> byte sequence identical to tready=1 run; tdata stable during stalls.
REQ-035 start pulses every cycle while busy -> exactly one frame; rst asserted at byte 20 -> tvalid=0 same cycle, frame_cnt=0.
REQ-036 frame_cnt preset to 16'hFFFF via 65535 frames (or forced) -> next completion yields 16'h0000, seed 8'hFF.
